// File: rtl/instr_fetch_arbiter.sv
// rtl/instr_fetch_arbiter.sv - four-core round-robin instruction fetch arbiter with a pipelined shared memory port
//
// Purpose:
//   Four cores share one synchronous instruction memory. Each cycle, one core is chosen
//   round-robin from the cores that are requesting and have no fetch in flight.
//   Its address is registered onto mem_addr, and its word comes back two cycles after the grant.
//   A new grant can be issued every cycle.
//
// Ports:
//   clock        rising-edge clock
//   reset_n      synchronous active-low reset
//   req[3:0]     per-core fetch request, held until that core's instr_valid
//   addr0..addr3 per-core fetch address (ADDR_W)
//   mem_addr     registered address to the shared memory (ADDR_W)
//   mem_data     memory read word, valid one cycle after mem_addr is registered (DATA_W)
//   gnt[3:0]     one-cycle grant pulse per granted core
//   instr_out    returned instruction word; holds its value between returns (DATA_W)
//   instr_valid  one-cycle pulse marking the core(s) that own instr_out
//   busy         high while any fetch is outstanding
//
// Configuration:
//   FETCH_COALESCE_EN  When defined, every eligible core whose address matches the winner's
//                      address is granted in the same cycle as the winner.
module instr_fetch_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [3:0]        req,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [ADDR_W-1:0] addr3,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [3:0]        gnt,
  output logic [DATA_W-1:0] instr_out,
  output logic [3:0]        instr_valid,
  output logic              busy
);

  logic [ADDR_W-1:0] addr_arr [4];
  logic [3:0]        outstanding;
  logic [3:0]        s1_mask;
  logic [3:0]        s2_mask;
  logic [1:0]        last_winner;

  logic [3:0]        eligible;
  logic [3:0]        grant_mask;
  logic [3:0]        outstanding_nxt;
  logic [1:0]        winner;
  logic [1:0]        idx;
  logic              found;

  assign addr_arr[0] = addr0;
  assign addr_arr[1] = addr1;
  assign addr_arr[2] = addr2;
  assign addr_arr[3] = addr3;

  always_comb begin
    eligible   = req & ~outstanding;
    found      = 1'b0;
    winner     = last_winner;
    idx        = 2'd0;
    // Walk the cores starting just after the last winner; the first eligible core wins.
    for (int k = 1; k <= 4; k++) begin
      idx = last_winner + 2'(k);
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    grant_mask = found ? (4'b0001 << winner) : 4'b0000;
`ifdef FETCH_COALESCE_EN
    for (int i = 0; i < 4; i++) begin
      if (found && eligible[i] && (addr_arr[i] == addr_arr[winner])) begin
        grant_mask[i] = 1'b1;
      end
    end
`endif
    // The grant and return bit sets never overlap, because a returning core is still outstanding.
    outstanding_nxt = (outstanding & ~s2_mask) | grant_mask;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      gnt         <= 4'b0000;
      instr_valid <= 4'b0000;
      outstanding <= 4'b0000;
      s1_mask     <= 4'b0000;
      s2_mask     <= 4'b0000;
      busy        <= 1'b0;
      instr_out   <= '0;
      mem_addr    <= '0;
      last_winner <= 2'd3;
    end else begin
      gnt         <= grant_mask;
      s1_mask     <= grant_mask;
      s2_mask     <= s1_mask;
      instr_valid <= s2_mask;
      outstanding <= outstanding_nxt;
      busy        <= |outstanding_nxt;
      if (found) begin
        mem_addr    <= addr_arr[winner];
        last_winner <= winner;
      end
      if (|s2_mask) begin
        instr_out <= mem_data;
      end
    end
  end

endmodule

// File: doc/instr_fetch_arbiter.md
INSTR_FETCH_ARBITER -- requirements
Module: instr_fetch_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the instruction address width.
REQ-002 Parameter DATA_W, default 8, SHALL set the instruction word width.
REQ-003 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  SHALL be the synchronous, active-low reset, sampled on the rising edge of clock.
REQ-005 req  input  4  SHALL carry one fetch request per core (bit i = core i), level-held until instr_valid[i].
REQ-006 addr0, addr1, addr2, addr3  input  ADDR_W each  SHALL carry each core's fetch address, stable while its req is high.
REQ-007 mem_addr  output  ADDR_W  SHALL drive the shared instruction memory address port.
REQ-008 mem_data  input  DATA_W  SHALL carry the memory read word, valid one clock after mem_addr is registered.
REQ-009 gnt  output  4  SHALL pulse for one cycle per granted core.
REQ-010 instr_out  output  DATA_W  SHALL carry the returned instruction word.
REQ-011 instr_valid  output  4  SHALL pulse for one cycle to mark the core(s) that own instr_out.
REQ-012 busy  output  1  SHALL be high while any fetch is outstanding.

Function
REQ-013 Eligible set SHALL be req & ~outstanding; requests from cores with an outstanding fetch SHALL be ignored.
REQ-014 Arbitration SHALL be round-robin: search starts at (last_winner+1) mod 4; last_winner updates on every grant.
REQ-015 Stage 1 (edge E0): if the eligible set is non-empty, register gnt mask, mem_addr = winner's address, s1_mask = gnt mask, and set outstanding for the granted cores; otherwise gnt = 0 and s1_mask = 0, and mem_addr holds.
REQ-016 Stage 2 (edge E1): the memory samples mem_addr, and s2_mask <= s1_mask.
REQ-017 Stage 3 (edge E2): instr_out <= mem_data, instr_valid <= s2_mask, and outstanding &= ~s2_mask.
REQ-018 Latency SHALL be exactly 2 cycles from the gnt pulse to instr_valid; one new grant SHALL be possible every cycle (fully pipelined).
REQ-019 A core's req sampled on the edge that asserts its instr_valid SHALL be ignored; it becomes eligible on the following edge.
REQ-020 instr_out SHALL hold its last value when instr_valid = 0.
REQ-021 busy SHALL equal |outstanding (registered).
REQ-022 With no eligible requests, the pipeline SHALL advance with zero masks, and no spurious instr_valid SHALL occur.

Reset
REQ-023 When reset_n = 0 at a rising edge: gnt, instr_valid, outstanding, s1_mask, s2_mask, busy = 0; instr_out = 0; mem_addr = 0; last_winner = 3, so core 0 has first priority.
REQ-024 Reset mid-operation SHALL discard in-flight fetches; no instr_valid SHALL be produced for fetches granted before reset.

Configuration
REQ-025 Macro FETCH_COALESCE_EN, when defined, SHALL additionally grant, in the same cycle, every eligible core whose address equals the winner's address; gnt, s1_mask and instr_valid are then multi-hot.
REQ-026 Without FETCH_COALESCE_EN, gnt SHALL be one-hot or zero, and identical addresses SHALL be served serially in round-robin order.

Verification
REQ-027 After reset, req = 4'b0100, addr2 = 8'd13, memory word 8'd5 -> gnt = 4'b0100 for 1 cycle, then 2 cycles later instr_valid = 4'b0100 and instr_out = 8'd5; busy is high in between.
REQ-028 After reset, req = 4'b1111 with addresses 0/7/13/20 -> gnt sequence 0001, 0010, 0100, 1000 on consecutive cycles, and instr_valid in the same order, 2 cycles later.
REQ-029 Cores 0 and 3 hold req continuously (re-request after each valid) -> grants alternate 0, 3, 0, 3, with no core starved for more than 1 grant slot.
REQ-030 All four addresses = 8'd28, memory word 8'd3 -> with FETCH_COALESCE_EN, gnt = 4'b1111 once and instr_valid = 4'b1111 with 8'd3; without the macro, 4 serial grants 0, 1, 2, 3.
REQ-031 reset_n = 0 for one cycle, on the edge after a grant to core 1 -> instr_valid stays 0 and busy = 0, and the next request from core 0 is granted first.
REQ-032 Core 2 keeps req high during its outstanding fetch -> no second gnt[2] until after its instr_valid[2]; the regrant occurs on the edge following that valid.
